// File: rtl/mul_div_unit_pkg.sv
// Shared processor definitions for the iterative multiply/divide unit:
// default datapath sizes, operation encodings and FSM state encodings.
package mul_div_unit_pkg;

  localparam int unsigned DEF_WIDTH    = 32;
  localparam int unsigned DEF_REG_BITS = 6;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIV  = 2'b10,
    OP_REM  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // DIV and REM share the upper encoding bit.
  function automatic logic op_is_div(op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: one shift-add (MUL/MULH) or restoring
// shift-subtract (DIV/REM) step per cycle on operand magnitudes, followed by
// a single sign-correction cycle and a one-cycle Done pulse.
// Ports:
//   Sys_Clock, Reset        clock, synchronous active-high reset
//   Start, Op, Is_Unsigned  request, operation, operand signedness
//   Abort                   flush; cancels any operation in progress
//   Operand_A, Operand_B    dividend/multiplicand, divisor/multiplier
//   Dest_Reg                writeback index captured with the operands
//   Busy, Done              operation in progress, one-cycle completion pulse
//   Result, Result_Reg      writeback data and index, held between Done pulses
//   Div_By_Zero             flags a DIV/REM with zero divisor, valid with Done
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned REG_BITS = DEF_REG_BITS
) (
  input  logic                Sys_Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic [1:0]          Op,
  input  logic                Is_Unsigned,
  input  logic                Abort,
  input  logic [WIDTH-1:0]    Operand_A,
  input  logic [WIDTH-1:0]    Operand_B,
  input  logic [REG_BITS-1:0] Dest_Reg,
  output logic                Busy,
  output logic                Done,
  output logic [WIDTH-1:0]    Result,
  output logic [REG_BITS-1:0] Result_Reg,
  output logic                Div_By_Zero
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW    = 2 * WIDTH;

  state_e              state;
  logic [CNT_W-1:0]    cnt_q;
  op_e                 op_q;
  logic                sign_a_q;
  logic                sign_b_q;
  logic                b_zero_q;
  logic [REG_BITS-1:0] dest_q;
  logic [WIDTH-1:0]    a_mag_q;
  logic [WIDTH-1:0]    b_mag_q;
  logic [WIDTH-1:0]    hi_q;
  logic [WIDTH-1:0]    lo_q;

  logic                a_neg_in;
  logic                b_neg_in;
  logic [WIDTH-1:0]    a_abs;
  logic [WIDTH-1:0]    b_abs;
  logic [WIDTH:0]      mul_sum;
  logic [WIDTH:0]      div_shift;
  logic                div_ge;
  logic [WIDTH-1:0]    hi_nxt;
  logic [WIDTH-1:0]    lo_nxt;
  logic [PW-1:0]       prod;
  logic [PW-1:0]       prod_s;
  logic [WIDTH-1:0]    quot_s;
  logic [WIDTH-1:0]    rem_s;
  logic [WIDTH-1:0]    fix_result;

  // Operand magnitudes captured at start.
  always_comb begin
    a_neg_in = ~Is_Unsigned & Operand_A[WIDTH-1];
    b_neg_in = ~Is_Unsigned & Operand_B[WIDTH-1];
    a_abs    = a_neg_in ? (WIDTH'(0) - Operand_A) : Operand_A;
    b_abs    = b_neg_in ? (WIDTH'(0) - Operand_B) : Operand_B;
  end

  // One iteration step. MUL: {hi,lo} holds partial product / remaining
  // multiplier bits. DIV: hi is the partial remainder, lo shifts the
  // dividend out and the quotient in.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, a_mag_q & {WIDTH{lo_q[0]}}};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_mag_q};
    if (op_is_div(op_q)) begin
      hi_nxt = div_ge ? WIDTH'(div_shift - {1'b0, b_mag_q}) : div_shift[WIDTH-1:0];
      lo_nxt = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Sign correction and word select. A zero divisor forces an all-ones
  // quotient and returns the original dividend as remainder.
  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = (sign_a_q ^ sign_b_q) ? (PW'(0) - prod) : prod;
    if (b_zero_q) begin
      quot_s = '1;
      rem_s  = sign_a_q ? (WIDTH'(0) - a_mag_q) : a_mag_q;
    end else begin
      quot_s = (sign_a_q ^ sign_b_q) ? (WIDTH'(0) - lo_q) : lo_q;
      rem_s  = sign_a_q ? (WIDTH'(0) - hi_q) : hi_q;
    end
    case (op_q)
      OP_MUL:  fix_result = prod_s[WIDTH-1:0];
      OP_MULH: fix_result = prod_s[PW-1:WIDTH];
      OP_DIV:  fix_result = quot_s;
      default: fix_result = rem_s;
    endcase
  end

  // Control FSM and datapath registers.
  always_ff @(posedge Sys_Clock) begin
    if (Reset) begin
      state       <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_MUL;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      b_zero_q    <= 1'b0;
      dest_q      <= '0;
      a_mag_q     <= '0;
      b_mag_q     <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Result      <= '0;
      Result_Reg  <= '0;
      Div_By_Zero <= 1'b0;
    end else begin
      Done        <= 1'b0;
      Div_By_Zero <= 1'b0;
      if (Abort) begin
        state <= ST_IDLE;
        Busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (Start) begin
              op_q     <= op_e'(Op);
              sign_a_q <= a_neg_in;
              sign_b_q <= b_neg_in;
              b_zero_q <= (Operand_B == '0);
              dest_q   <= Dest_Reg;
              a_mag_q  <= a_abs;
              b_mag_q  <= b_abs;
              hi_q     <= '0;
              lo_q     <= Op[1] ? a_abs : b_abs;
              cnt_q    <= CNT_W'(WIDTH - 1);
              Busy     <= 1'b1;
              state    <= ST_RUN;
            end
          end
          ST_RUN: begin
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
            if (cnt_q == '0) begin
              state <= ST_FIX;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          ST_FIX: begin
            Result      <= fix_result;
            Result_Reg  <= dest_q;
            Div_By_Zero <= op_is_div(op_q) & b_zero_q;
            Done        <= 1'b1;
            Busy        <= 1'b0;
            state       <= ST_DONE;
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32, REG_BITS=6).
// Cycle n is the interval after the n-th rising edge counted from the cycle
// in which Start is driven; outputs are sampled 1 time unit after each edge.
module tb_mul_div_unit;

  localparam int unsigned W  = 32;
  localparam int unsigned RB = 6;

  logic          Sys_Clock = 1'b0;
  logic          Reset;
  logic          Start;
  logic [1:0]    Op;
  logic          Is_Unsigned;
  logic          Abort;
  logic [W-1:0]  Operand_A;
  logic [W-1:0]  Operand_B;
  logic [RB-1:0] Dest_Reg;
  logic          Busy;
  logic          Done;
  logic [W-1:0]  Result;
  logic [RB-1:0] Result_Reg;
  logic          Div_By_Zero;

  mul_div_unit #(.WIDTH(W), .REG_BITS(RB)) dut (
    .Sys_Clock  (Sys_Clock),
    .Reset      (Reset),
    .Start      (Start),
    .Op         (Op),
    .Is_Unsigned(Is_Unsigned),
    .Abort      (Abort),
    .Operand_A  (Operand_A),
    .Operand_B  (Operand_B),
    .Dest_Reg   (Dest_Reg),
    .Busy       (Busy),
    .Done       (Done),
    .Result     (Result),
    .Result_Reg (Result_Reg),
    .Div_By_Zero(Div_By_Zero)
  );

  always #5 Sys_Clock = ~Sys_Clock;

  int            n_cmp;
  int            n_fail;
  int            cyc;
  int            done_cnt;
  int            done_cyc;
  logic [W-1:0]  done_res;
  logic [RB-1:0] done_reg;
  logic          done_dbz;
  logic          busy_log [0:127];

  typedef struct {
    logic [1:0]    op;
    logic          uns;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  exp;
    logic          dbz;
    logic [RB-1:0] dest;
  } vec_t;

  // Advance one cycle and record Busy and any Done pulse.
  task automatic tick();
    @(posedge Sys_Clock);
    #1;
    cyc++;
    if (cyc < 128) busy_log[cyc] = Busy;
    if (Done) begin
      done_cnt++;
      done_cyc = cyc;
      done_res = Result;
      done_reg = Result_Reg;
      done_dbz = Div_By_Zero;
    end
  endtask

  // Drive Start for one cycle; that cycle becomes cycle 0.
  task automatic launch(input logic [1:0] op, input logic uns, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [RB-1:0] dest);
    Op = op; Is_Unsigned = uns; Operand_A = a; Operand_B = b; Dest_Reg = dest;
    Start = 1'b1;
    cyc = 0; done_cnt = 0; done_cyc = -1;
    for (int i = 0; i < 128; i++) busy_log[i] = 1'b0;
    tick();
    Start = 1'b0;
  endtask

  task automatic run_until(input int last);
    while (cyc < last) tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Start = 1'b1;
    tick();
    tick();
    Start = 1'b0;
    n_cmp++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_cmp++;
    if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", Done); end
    n_cmp++;
    if (Result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", Result); end
    n_cmp++;
    if (Result_Reg !== 6'd0) begin n_fail++; $display("FAIL reset_result_reg: got %0d want 0", Result_Reg); end
    n_cmp++;
    if (Div_By_Zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", Div_By_Zero); end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_ops();
    vec_t v [17];
    v = '{
      '{2'd0, 1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 6'd1},
      '{2'd1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 6'd2},
      '{2'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 6'd3},
      '{2'd1, 1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 6'd4},
      '{2'd1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 6'd5},
      '{2'd2, 1'b0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 6'd6},
      '{2'd3, 1'b0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 6'd7},
      '{2'd2, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 1'b0, 6'd8},
      '{2'd3, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 1'b0, 6'd9},
      '{2'd2, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 6'd10},
      '{2'd3, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 6'd11},
      '{2'd2, 1'b0, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1'b1, 6'd12},
      '{2'd3, 1'b0, 32'h00001234, 32'h00000000, 32'h00001234, 1'b1, 6'd13},
      '{2'd3, 1'b0, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 1'b1, 6'd14},
      '{2'd2, 1'b0, 32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 6'd15},
      '{2'd3, 1'b0, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 1'b0, 6'd0},
      '{2'd1, 1'b1, 32'h00010000, 32'h00010000, 32'h00000001, 1'b0, 6'd63}
    };
    for (int i = 0; i < 17; i++) begin
      launch(v[i].op, v[i].uns, v[i].a, v[i].b, v[i].dest);
      run_until(40);
      n_cmp++;
      if (done_cnt !== 1) begin n_fail++; $display("FAIL op%0d_done_count: got %0d want 1", i, done_cnt); end
      n_cmp++;
      if (done_cyc !== 34) begin n_fail++; $display("FAIL op%0d_done_cycle: got %0d want 34", i, done_cyc); end
      n_cmp++;
      if (done_res !== v[i].exp) begin n_fail++; $display("FAIL op%0d_result: got %h want %h", i, done_res, v[i].exp); end
      n_cmp++;
      if (done_dbz !== v[i].dbz) begin n_fail++; $display("FAIL op%0d_div_by_zero: got %b want %b", i, done_dbz, v[i].dbz); end
      n_cmp++;
      if (done_reg !== v[i].dest) begin n_fail++; $display("FAIL op%0d_result_reg: got %0d want %0d", i, done_reg, v[i].dest); end
      n_cmp++;
      if ({busy_log[1], busy_log[33], busy_log[34]} !== 3'b110) begin
        n_fail++;
        $display("FAIL op%0d_busy_window: got c1=%b c33=%b c34=%b want 1 1 0", i, busy_log[1], busy_log[33], busy_log[34]);
      end
    end
  endtask

  task automatic test_hold();
    run_until(50);
    n_cmp++;
    if (Result !== 32'h00000001) begin n_fail++; $display("FAIL hold_result: got %h want 00000001", Result); end
    n_cmp++;
    if (Result_Reg !== 6'd63) begin n_fail++; $display("FAIL hold_result_reg: got %0d want 63", Result_Reg); end
  endtask

  task automatic test_start_while_busy();
    launch(2'd0, 1'b1, 32'd3, 32'd4, 6'd5);
    run_until(10);
    Op = 2'd2; Operand_A = 32'd100; Operand_B = 32'd5; Dest_Reg = 6'd9;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    run_until(45);
    n_cmp++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL busy_start_done_count: got %0d want 1", done_cnt); end
    n_cmp++;
    if (done_cyc !== 34) begin n_fail++; $display("FAIL busy_start_done_cycle: got %0d want 34", done_cyc); end
    n_cmp++;
    if (done_reg !== 6'd5) begin n_fail++; $display("FAIL busy_start_result_reg: got %0d want 5", done_reg); end
    n_cmp++;
    if (done_res !== 32'd12) begin n_fail++; $display("FAIL busy_start_result: got %h want 0000000c", done_res); end
  endtask

  task automatic test_abort();
    launch(2'd0, 1'b1, 32'd3, 32'd4, 6'd7);
    run_until(20);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    n_cmp++;
    if ({busy_log[20], Busy} !== 2'b10) begin n_fail++; $display("FAIL abort_busy: got c20=%b c21=%b want 1 0", busy_log[20], Busy); end
    tick();
    Op = 2'd0; Is_Unsigned = 1'b1; Operand_A = 32'd6; Operand_B = 32'd7; Dest_Reg = 6'd8;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    run_until(60);
    n_cmp++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL abort_done_count: got %0d want 1", done_cnt); end
    n_cmp++;
    if (done_cyc !== 56) begin n_fail++; $display("FAIL abort_restart_cycle: got %0d want 56", done_cyc); end
    n_cmp++;
    if (done_res !== 32'd42) begin n_fail++; $display("FAIL abort_restart_result: got %h want 0000002a", done_res); end
  endtask

  task automatic test_abort_start_idle();
    Op = 2'd0; Operand_A = 32'd2; Operand_B = 32'd2; Dest_Reg = 6'd1;
    cyc = 0; done_cnt = 0;
    Abort = 1'b1;
    Start = 1'b1;
    tick();
    Abort = 1'b0;
    Start = 1'b0;
    n_cmp++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL abort_wins_busy: got %b want 0", Busy); end
    run_until(40);
    n_cmp++;
    if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_wins_done_count: got %0d want 0", done_cnt); end
  endtask

  task automatic test_back_to_back();
    launch(2'd0, 1'b1, 32'd5, 32'd5, 6'd1);
    run_until(34);
    Op = 2'd2; Operand_A = 32'd9; Operand_B = 32'd3; Dest_Reg = 6'd2;
    Start = 1'b1;
    tick();
    tick();
    Start = 1'b0;
    run_until(75);
    n_cmp++;
    if (done_cnt !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
    n_cmp++;
    if (done_cyc !== 69) begin n_fail++; $display("FAIL b2b_second_done_cycle: got %0d want 69", done_cyc); end
    n_cmp++;
    if (done_res !== 32'd3) begin n_fail++; $display("FAIL b2b_second_result: got %h want 00000003", done_res); end
    n_cmp++;
    if (done_reg !== 6'd2) begin n_fail++; $display("FAIL b2b_second_result_reg: got %0d want 2", done_reg); end
  endtask

  task automatic test_reset_mid();
    launch(2'd0, 1'b1, 32'd3, 32'd4, 6'd11);
    run_until(15);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_cmp++;
    if ({Busy, Done, Div_By_Zero, Result, Result_Reg} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b dbz=%b result=%h reg=%0d want all 0",
               Busy, Done, Div_By_Zero, Result, Result_Reg);
    end
    run_until(40);
    n_cmp++;
    if (done_cnt !== 0) begin n_fail++; $display("FAIL reset_mid_done_count: got %0d want 0", done_cnt); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; done_cnt = 0; done_cyc = -1;
    done_res = '0; done_reg = '0; done_dbz = 1'b0;
    Reset = 1'b1; Start = 1'b0; Op = 2'd0; Is_Unsigned = 1'b0; Abort = 1'b0;
    Operand_A = '0; Operand_B = '0; Dest_Reg = '0;
    test_reset();
    test_ops();
    test_hold();
    test_start_while_busy();
    test_abort();
    test_abort_start_idle();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width; iteration count equals WIDTH.
REQ-002 SHALL have parameter REG_BITS, default 6: destination-register index width, matching the 64-entry register file.
REQ-003 Sys_Clock  in  1  single clock; all state updates on the rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 Start  in  1  request; sampled only in IDLE.
REQ-006 Op  in  2  operation: 00 MUL (low word), 01 MULH (high word), 10 DIV (quotient), 11 REM (remainder).
REQ-007 Is_Unsigned  in  1  1 = unsigned operands; 0 = two's-complement.
REQ-008 Abort  in  1  pipeline flush; cancels any operation in progress.
REQ-009 Operand_A, Operand_B  in  WIDTH each  multiplicand/dividend and multiplier/divisor, taken from register-file Data_1/Data_2.
REQ-010 Dest_Reg  in  REG_BITS  writeback register index, captured with the operands.
REQ-011 Busy  out  1  operation in progress.
REQ-012 Done  out  1  one-cycle pulse; Result, Result_Reg and Div_By_Zero are valid for that cycle.
REQ-013 Result  out  WIDTH  write data for the register-file write port.
REQ-014 Result_Reg  out  REG_BITS  destination index for the register-file write port.
REQ-015 Div_By_Zero  out  1  asserted with Done when a DIV/REM had Operand_B = 0.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, FIX and DONE.
REQ-017 IDLE->RUN occurs when Start=1 and Abort=0; Op, Is_Unsigned, Dest_Reg and the operand magnitudes (absolute values when signed) SHALL be latched on that edge.
REQ-018 RUN SHALL perform exactly WIDTH iterations, one per cycle: shift-add for MUL/MULH, restoring shift-subtract for DIV/REM; a counter SHALL run from WIDTH-1 down to 0, and RUN->FIX occurs at 0.
REQ-019 FIX SHALL take one cycle to apply sign correction and select the word; then FIX->DONE.
REQ-020 DONE SHALL last one cycle with Done=1 and Busy=0, then DONE->IDLE; a Start in the DONE cycle SHALL be ignored.
REQ-021 Latency: with Start in cycle 0, Busy SHALL be 1 in cycles 1..WIDTH+1 and Done SHALL be 1 in cycle WIDTH+2 (34 for WIDTH=32).
REQ-022 The product SHALL be 2*WIDTH bits; MUL returns bits [WIDTH-1:0], MULH returns bits [2*WIDTH-1:WIDTH].
REQ-023 Signed product sign = sign(A) XOR sign(B); quotient sign = sign(A) XOR sign(B); remainder sign = sign(A), so division truncates toward zero.
REQ-024 Divide by zero: quotient SHALL be all ones, remainder SHALL equal Operand_A, Div_By_Zero=1, with normal latency.
REQ-025 Signed DIV of the most-negative value by -1 SHALL give quotient = most-negative value and remainder 0, with no flag.
REQ-026 A Start while Busy=1 SHALL be ignored, with no queuing.
REQ-027 Abort=1 in any state SHALL return the FSM to IDLE on the next edge with no Done pulse; if Abort and Start are both 1 in IDLE, Abort wins.
REQ-028 Result and Result_Reg SHALL hold their values from the last Done until the next Done.
REQ-029 Dest_Reg = 0 SHALL complete normally; suppressing the write is left to the register file.

Reset
REQ-030 While Reset=1 at an edge, the FSM SHALL go to IDLE and Busy, Done, Div_By_Zero, Result, Result_Reg and the counter SHALL all be 0.
REQ-031 Reset during RUN or FIX SHALL discard the operation with no Done pulse.
REQ-032 Reset SHALL take priority over Abort and Start.

Structure
REQ-033 The Op encodings, FSM state encodings and the default WIDTH/REG_BITS constants SHALL live in the shared processor package.
REQ-034 The FSM and datapath SHALL be implemented in the single module mul_div_unit, with no sub-module.

Verification
REQ-035 MUL, signed, A=7, B=0xFFFFFFFD (-3) -> Result=0xFFFFFFEB in cycle 34; MULH unsigned, A=B=0xFFFFFFFF -> Result=0xFFFFFFFE.
REQ-036 DIV, signed, A=0xFFFFFFF9 (-7), B=2 -> Result=0xFFFFFFFD; REM with the same operands -> Result=0xFFFFFFFF; Div_By_Zero=0.
REQ-037 DIV, A=0x1234, B=0 -> Result=0xFFFFFFFF, Div_By_Zero=1; REM with the same operands -> Result=0x1234, Div_By_Zero=1.
REQ-038 Start, Dest_Reg=5; second Start in cycle 10 with Dest_Reg=9 -> exactly one Done, in cycle 34, with Result_Reg=5.
REQ-039 Abort in cycle 20 -> Busy=0 in cycle 21 and no Done; a Start in cycle 22 -> Done in cycle 56.
REQ-040 Reset in cycle 15 of an operation -> all outputs 0 in cycle 16 and no Done through cycle 40.
